// File: rtl/dec_to_bin_seq.sv
// Sign + packed-BCD to binary converter, one digit per clock, MS digit first; result NDIG edges after accept.
// Single operand in flight: in_ready only in IDLE, result held in DONE until out_ready.
module dec_to_bin_seq #(
    parameter int NDIG      = 3,
    parameter int WOUT      = 8,
    parameter int SIGN_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    input  logic              in_neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WOUT-1:0]   out_bin,
    output logic              out_ovf,
    output logic              out_err
);

    localparam int AW = WOUT + 4;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST    = CW'(NDIG - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] LIM_POS = (ONE << (WOUT - 1)) - ONE;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    typedef struct packed {
        logic              neg;
        logic [4*NDIG-1:0] bcd;
    } op_t;

    typedef struct packed {
        logic [WOUT-1:0] bin;
        logic            ovf;
        logic            err;
    } res_t;

    state_t        state;
    op_t           op;
    logic [AW-1:0] acc;
    logic [CW-1:0] dcnt;
    logic          err_q;
    logic          ovf_q;
    res_t          res;

    logic [3:0]      digit;
    logic [AW-1:0]   limit;
    logic [AW-1:0]   acc_x10;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   acc_nxt;
    logic            step_ovf;
    logic            err_nxt;
    logic            ovf_nxt;
    logic [WOUT-1:0] mag;
    logic [WOUT-1:0] sat_bin;
    logic [WOUT-1:0] fmt_bin;
    res_t            res_nxt;

    // The operand is shifted left each step, so the digit in use is always the top nibble.
    assign digit = op.bcd[4*NDIG-1 -: 4];

    generate
        if (SIGN_MODE == 1) begin : g_twos
            localparam logic [AW-1:0] LIM_NEG = ONE << (WOUT - 1);
            assign limit   = op.neg ? LIM_NEG : LIM_POS;
            assign sat_bin = op.neg ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
            assign fmt_bin = op.neg ? (~mag + WOUT'(1)) : mag;
        end else begin : g_sm
            assign limit   = LIM_POS;
            assign sat_bin = {op.neg, {(WOUT-1){1'b1}}};
            // Negative zero collapses to plain zero.
            assign fmt_bin = {op.neg & (|mag), mag[WOUT-2:0]};
        end
    endgenerate

    always_comb begin
        acc_x10  = (acc << 3) + (acc << 1);
        acc_sum  = acc_x10 + AW'(digit);
        step_ovf = (acc_sum > limit);
        err_nxt  = err_q | (digit > 4'd9);
        ovf_nxt  = ovf_q | step_ovf;
        // Clamp just above the limit so later multiplies cannot wrap the accumulator.
        acc_nxt  = step_ovf ? (limit + ONE) : acc_sum;
        mag      = acc_sum[WOUT-1:0];
    end

    always_comb begin
        res_nxt = '0;
        if (err_nxt) begin
            res_nxt.err = 1'b1;
        end else if (ovf_nxt) begin
            res_nxt.bin = sat_bin;
            res_nxt.ovf = 1'b1;
        end else begin
            res_nxt.bin = fmt_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            acc       <= '0;
            dcnt      <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op.neg   <= in_neg;
                        op.bcd   <= in_bcd;
                        acc      <= '0;
                        dcnt     <= '0;
                        err_q    <= 1'b0;
                        ovf_q    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc    <= acc_nxt;
                    err_q  <= err_nxt;
                    ovf_q  <= ovf_nxt;
                    dcnt   <= dcnt + CW'(1);
                    op.bcd <= op.bcd << 4;
                    if (dcnt == LAST) begin
                        res       <= res_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_bin = res.bin;
    assign out_ovf = res.ovf;
    assign out_err = res.err;

endmodule

// File: tb/tb_dec_to_bin_seq.sv
// Bench for dec_to_bin_seq: two NDIG=3/WOUT=8 instances (both sign modes) in lockstep plus a 4-digit 16-bit one.
module tb_dec_to_bin_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        in_valid  = 1'b0;
    logic [11:0] in_bcd    = '0;
    logic        in_neg    = 1'b0;
    logic        out_ready = 1'b0;

    logic       rdy_a, vld_a, ovf_a, err_a;
    logic [7:0] bin_a;
    logic       rdy_b, vld_b, ovf_b, err_b;
    logic [7:0] bin_b;

    logic        c_in_valid  = 1'b0;
    logic [15:0] c_in_bcd    = '0;
    logic        c_in_neg    = 1'b0;
    logic        c_out_ready = 1'b1;
    logic        c_rdy, c_vld, c_ovf, c_err;
    logic [15:0] c_bin;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dec_to_bin_seq #(.NDIG(3), .WOUT(8), .SIGN_MODE(0)) u_sm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_bcd(in_bcd), .in_neg(in_neg), .out_valid(vld_a), .out_ready(out_ready),
        .out_bin(bin_a), .out_ovf(ovf_a), .out_err(err_a)
    );

    dec_to_bin_seq #(.NDIG(3), .WOUT(8), .SIGN_MODE(1)) u_tc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_bcd(in_bcd), .in_neg(in_neg), .out_valid(vld_b), .out_ready(out_ready),
        .out_bin(bin_b), .out_ovf(ovf_b), .out_err(err_b)
    );

    dec_to_bin_seq #(.NDIG(4), .WOUT(16), .SIGN_MODE(1)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_rdy),
        .in_bcd(c_in_bcd), .in_neg(c_in_neg), .out_valid(c_vld), .out_ready(c_out_ready),
        .out_bin(c_bin), .out_ovf(c_ovf), .out_err(c_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the digits, then range and sign rules applied arithmetically.
    // Returns {err, ovf, bin[31:0]}.
    function automatic logic [33:0] model(input logic [31:0] bcd, input bit neg,
                                          input int ndig, input int wout, input int mode);
        longint val = 0;
        longint lim, mask, top;
        bit err = 0;
        bit ovf = 0;
        logic [31:0] bin;
        for (int k = ndig - 1; k >= 0; k--) begin
            int d;
            d = int'((bcd >> (4 * k)) & 32'hF);
            if (d > 9) err = 1;
            val = val * 10 + d;
        end
        top  = longint'(1) << (wout - 1);
        mask = (longint'(1) << wout) - 1;
        lim  = (mode == 1 && neg) ? top : top - 1;
        if (err) begin
            bin = 0;
        end else if (val > lim) begin
            ovf = 1;
            if (mode == 0) bin = 32'(neg ? mask : top - 1);
            else           bin = 32'(neg ? ((-lim) & mask) : lim);
        end else if (mode == 0) begin
            bin = 32'((neg && val != 0) ? (val | top) : val);
        end else begin
            bin = 32'(neg ? ((-val) & mask) : val);
        end
        return {err, ovf, bin};
    endfunction

    // Entered #1 after a rising edge. hold = cycles of out_ready=0 in DONE;
    // keep = leave in_valid high after acceptance (the next call's operand is then pending).
    task automatic do_ab(input logic [11:0] bcd, input bit neg, input int hold, input bit keep,
                         output logic [7:0] got_a, output logic [7:0] got_b);
        logic [33:0] ea, eb;
        logic [31:0] ra, rb;
        ea = model({20'd0, bcd}, neg, 3, 8, 0);
        eb = model({20'd0, bcd}, neg, 3, 8, 1);
        ra = {22'd0, ea[33], ea[32], ea[7:0]};
        rb = {22'd0, eb[33], eb[32], eb[7:0]};
        in_bcd    = bcd;
        in_neg    = neg;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        for (int t = 0; t < 30 && !(rdy_a && rdy_b); t++) begin
            @(posedge clk); #1;
        end
        chk("accept_rdy", {30'd0, rdy_b, rdy_a}, 32'd3);
        @(posedge clk); #1;
        in_valid = keep;
        in_bcd   = 12'($urandom);
        in_neg   = 1'($urandom);
        repeat (3) begin
            chk("busy", {28'd0, vld_b, vld_a, rdy_b, rdy_a}, 32'd0);
            @(posedge clk); #1;
        end
        chk("valid_at_ndig", {28'd0, vld_b, vld_a, rdy_b, rdy_a}, 32'hC);
        chk("res_sm", {22'd0, err_a, ovf_a, bin_a}, ra);
        chk("res_tc", {22'd0, err_b, ovf_b, bin_b}, rb);
        got_a = bin_a;
        got_b = bin_b;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_flags", {28'd0, vld_b, vld_a, rdy_b, rdy_a}, 32'hC);
            chk("hold_sm", {22'd0, err_a, ovf_a, bin_a}, ra);
            chk("hold_tc", {22'd0, err_b, ovf_b, bin_b}, rb);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff", {28'd0, vld_b, vld_a, rdy_b, rdy_a}, 32'h3);
        chk("retain_sm", {22'd0, err_a, ovf_a, bin_a}, ra);
        chk("retain_tc", {22'd0, err_b, ovf_b, bin_b}, rb);
    endtask

    task automatic do_c(input logic [15:0] bcd, input bit neg, output logic [15:0] got);
        logic [33:0] ec;
        ec = model({16'd0, bcd}, neg, 4, 16, 1);
        c_in_bcd   = bcd;
        c_in_neg   = neg;
        c_in_valid = 1'b1;
        for (int t = 0; t < 30 && !c_rdy; t++) begin
            @(posedge clk); #1;
        end
        chk("c_accept_rdy", {31'd0, c_rdy}, 32'd1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        c_in_bcd   = 16'($urandom);
        repeat (4) begin
            chk("c_busy", {30'd0, c_vld, c_rdy}, 32'd0);
            @(posedge clk); #1;
        end
        chk("c_valid", {30'd0, c_vld, c_rdy}, 32'h2);
        chk("c_res", {14'd0, c_err, c_ovf, c_bin}, {14'd0, ec[33], ec[32], ec[15:0]});
        got = c_bin;
        @(posedge clk); #1;
        chk("c_handoff", {30'd0, c_vld, c_rdy}, 32'h1);
    endtask

    localparam int ND = 10;
    logic [11:0] d_bcd   [ND] = '{12'h127, 12'h125, 12'h000, 12'h200, 12'h128,
                                  12'h129, 12'h1A3, 12'hF99, 12'h999, 12'h042};
    bit          d_neg   [ND] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0};
    int          d_hold  [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0};
    bit          d_keep  [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0]  d_exp_a [ND] = '{8'h7F, 8'hFD, 8'h00, 8'h7F, 8'hFF,
                                  8'hFF, 8'h00, 8'h00, 8'hFF, 8'h2A};
    logic [7:0]  d_exp_b [ND] = '{8'h7F, 8'h83, 8'h00, 8'h7F, 8'h80,
                                  8'h80, 8'h00, 8'h00, 8'h80, 8'h2A};

    initial begin
        logic [7:0]  ga, gb;
        logic [15:0] gc;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_sm", {20'd0, rdy_a, vld_a, err_a, ovf_a, bin_a}, 32'h800);
        chk("rst_tc", {20'd0, rdy_b, vld_b, err_b, ovf_b, bin_b}, 32'h800);
        chk("rst_wide", {12'd0, c_rdy, c_vld, c_err, c_ovf, c_bin}, 32'h80000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < ND; i++) begin
            do_ab(d_bcd[i], d_neg[i], d_hold[i], d_keep[i], ga, gb);
            chk($sformatf("tbl_sm_%0d", i), {24'd0, ga}, {24'd0, d_exp_a[i]});
            chk($sformatf("tbl_tc_%0d", i), {24'd0, gb}, {24'd0, d_exp_b[i]});
        end

        for (int n = 0; n < 40; n++) begin
            logic [11:0] b;
            for (int k = 0; k < 3; k++)
                b[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            do_ab(b, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), ga, gb);
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Abort in the 2nd CONV cycle; a non-zero result is on the outputs beforehand.
        do_ab(12'h127, 1'b0, 0, 1'b0, ga, gb);
        in_bcd   = 12'h999;
        in_neg   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sm", {20'd0, rdy_a, vld_a, err_a, ovf_a, bin_a}, 32'h800);
        chk("arst_tc", {20'd0, rdy_b, vld_b, err_b, ovf_b, bin_b}, 32'h800);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold", {28'd0, vld_b, vld_a, rdy_b, rdy_a}, 32'h3);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_ab(12'h042, 1'b0, 0, 1'b0, ga, gb);
        chk("fresh_042", {24'd0, ga}, 32'h2A);

        do_c(16'h9999, 1'b0, gc);
        chk("wide_9999", {16'd0, gc}, 32'h270F);
        do_c(16'h0000, 1'b1, gc);
        chk("wide_negzero", {16'd0, gc}, 32'h0);
        for (int n = 0; n < 20; n++) begin
            logic [15:0] b;
            for (int k = 0; k < 4; k++)
                b[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            do_c(b, 1'($urandom), gc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dec_to_bin_seq.md
Name: dec_to_bin_seq

Overview:
- Sequential, parametrised successor to the combinational sign+BCD-to-binary converter used by the calculator.
- Accepts an NDIG-digit packed BCD magnitude plus a sign flag over a valid/ready handshake.
- Converts iteratively, one digit per clock, most significant digit first.
- Returns a WOUT-bit signed result with overflow and invalid-digit flags to the register bank / ALU front end.

Parameters:
- NDIG, 3, number of BCD digits in in_bcd (1..8).
- WOUT, 8, width of out_bin (4..32).
- SIGN_MODE, 0, 0 = sign-magnitude output (MSB is sign, WOUT-1 magnitude bits); 1 = two's-complement output.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a valid operand.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- in_bcd  in  4*NDIG  packed BCD; digit k at bits [4k+3:4k]; digit 0 is units.
- in_neg  in  1  operand is negative.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- out_bin  out  WOUT  converted result.
- out_ovf  out  1  magnitude exceeded range; out_bin saturated.
- out_err  out  1  some digit > 9; out_bin forced to 0.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_bin=0, out_ovf=0, out_err=0, and all internal registers 0.
- Reset is asynchronous. Asserting it mid-conversion aborts immediately; no result is produced.
- FSM has three states: IDLE, CONV, DONE.
- IDLE -> CONV on the edge where in_valid & in_ready.
  - Latch in_bcd and in_neg.
  - Clear the accumulator (WOUT+4 bits wide), the digit counter, and the sticky err/ovf flags.
- CONV, one edge per digit, from digit NDIG-1 down to digit 0:
  - acc <= acc*10 + digit.
  - err sticky-sets if digit > 9.
  - ovf sticky-sets if acc exceeds LIMIT at any step. Saturate acc at LIMIT+1 so the accumulator never wraps.
- LIMIT:
  - SIGN_MODE=0: 2^(WOUT-1)-1 for both signs.
  - SIGN_MODE=1: 2^(WOUT-1)-1 if positive, 2^(WOUT-1) if negative.
- On the final CONV edge, register the outputs and go to DONE:
  - out_err=1: out_bin=0, out_ovf=0 (error takes precedence).
  - Else out_ovf=1: out_bin = saturated value (largest magnitude for the sign).
  - Else SIGN_MODE=0: out_bin = {in_neg & (mag!=0), mag[WOUT-2:0]}. Negative zero is emitted as 0.
  - Else SIGN_MODE=1: out_bin = in_neg ? -mag : mag (two's complement).
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge.
- DONE: out_valid=1 and out_bin/out_ovf/out_err are held stable while out_ready=0.
- DONE -> IDLE on the edge where out_valid & out_ready. in_ready returns high on the following cycle.
  - An operand is never accepted in the same cycle as result handoff.
  - Throughput is one conversion per NDIG+2 cycles minimum.
- out_bin, out_ovf and out_err retain their last values after the handshake until the next conversion overwrites them.
- in_bcd and in_neg are ignored outside the accepting edge. Changing them during CONV has no effect.
- in_valid held high continuously is legal: the next operand is accepted on the first cycle back in IDLE.

Test Plan:
- Latency and basic conversion (NDIG=3, WOUT=8, SIGN_MODE=0): in_bcd=0x127, in_neg=0, out_ready=1.
  - out_valid exactly 3 edges after accept.
  - out_bin=0x7F, ovf=0, err=0.
  - in_ready=0 during CONV/DONE, 1 again after handoff.
- Negative operand, in_bcd=0x125, in_neg=1:
  - SIGN_MODE=0 -> out_bin=0xFD.
  - SIGN_MODE=1 -> out_bin=0x83.
  - in_bcd=0x000, in_neg=1 -> out_bin=0x00 in both modes.
- Range limits:
  - in_bcd=0x200, in_neg=0 -> out_ovf=1, out_bin=0x7F.
  - SIGN_MODE=1, in_bcd=0x128, in_neg=1 -> out_bin=0x80, ovf=0.
  - SIGN_MODE=1, in_bcd=0x129, in_neg=1 -> ovf=1, out_bin=0x80.
  - NDIG=4, WOUT=16, in_bcd=0x9999 -> out_bin=0x270F.
- Invalid digit, in_bcd=0x1A3 -> out_err=1, out_bin=0x00, out_ovf=0.
  - In_bcd=0xF99 -> out_err=1, out_ovf=0 (error precedence over overflow).
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid, out_bin and flags stay stable; in_ready stays 0 despite in_valid=1.
  - Release out_ready: the pending operand is accepted one cycle after handoff.
- Reset mid-operation: assert rst_n=0 during the 2nd CONV cycle.
  - All outputs return to their reset values immediately (asynchronously), with in_ready=1.
  - After release, a fresh conversion of 0x042 returns 0x2A.
